// File: rtl/sfilt_pkg.sv
// Shared definitions for the serial-filter command sequencer.
// Contents: datapath/shift widths, filter command codes and the sequencer
// state enumeration used by sfilt_seq (and exposed on its debug port).
package sfilt_pkg;

  localparam int DW  = 32;  // sample / coefficient width
  localparam int SHW = 7;   // shift-amount width carried in h[6:0]

  localparam logic [1:0] CMD_FIRST = 2'd0;  // q*h, start new accumulation
  localparam logic [1:0] CMD_MAC   = 2'd1;  // acc += q*h
  localparam logic [1:0] CMD_SHIFT = 2'd2;  // acc >>= h[6:0] with rounding
  localparam logic [1:0] CMD_SEND  = 2'd3;  // emit acc and clear

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    MAC,
    SHIFT,
    SEND
  } seq_state_t;

endpackage

// File: rtl/sfilt_dline.sv
// Circular delay line holding the last NTAPS accepted samples.
// Ports:
//   clk, rst      clock / synchronous active-high clear of all entries
//   i_wr_en       write the sample at the write pointer, then advance it
//   i_wr_data     sample to store
//   i_koff        tap offset k; read returns the sample k accepts ago
//   o_rd_data     dline[(latest - k) mod NTAPS], combinational
module sfilt_dline
  import sfilt_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_koff,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [NTAPS];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_latest;
  logic [AW-1:0] w_rd_idx;

  // Explicit modulo subtraction so NTAPS need not be a power of two.
  function automatic logic [AW-1:0] tap_idx(input logic [AW-1:0] latest,
                                             input logic [AW-1:0] koff);
    int l;
    int o;
    int t;
    l = int'(latest);
    o = int'(koff);
    t = (l >= o) ? (l - o) : (l + NTAPS - o);
    return AW'(t);
  endfunction

  assign w_rd_idx  = tap_idx(r_latest, i_koff);
  assign o_rd_data = r_mem[w_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) r_mem[i] <= '0;
      r_wp     <= '0;
      r_latest <= '0;
    end else if (i_wr_en) begin
      r_mem[r_wp] <= i_wr_data;
      r_latest    <= r_wp;
      r_wp        <= (int'(r_wp) == NTAPS - 1) ? '0 : r_wp + AW'(1);
    end
  end

endmodule

// File: rtl/sfilt_seq.sv
// Command sequencer / initiator for the serial FIR filter.
// For every accepted sample it issues one frame of NTAPS+2 commands, one per
// cycle: first-mult, NTAPS-1 mult-accumulates, shift/round, send-and-clear.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   cload/cidx/cdata coefficient write (honoured in IDLE only)
//   load_err        one-cycle pulse, cycle after a dropped cload
//   shift_amt       right shift for the frame, latched on accept
//   pushin/x/ready  sample input
//   pushout/cmd/q/h command stream to the filter (registered)
//   dbg_state       current sequencer state
//
// Handshake: a sample is taken on a rising edge where pushin && ready.
// ready is high only in IDLE and SEND. The filter side has no backpressure:
// pushout is a pure valid, high for every cycle of a frame.
module sfilt_seq
  import sfilt_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cload,
  input  logic [AW-1:0]  cidx,
  input  logic [DW-1:0]  cdata,
  output logic           load_err,
  input  logic [SHW-1:0] shift_amt,
  input  logic           pushin,
  input  logic [DW-1:0]  x,
  output logic           ready,
  output logic           pushout,
  output logic [1:0]     cmd,
  output logic [DW-1:0]  q,
  output logic [DW-1:0]  h,
  output seq_state_t     dbg_state
);

  seq_state_t     r_state;
  logic [AW-1:0]  r_k;
  logic [SHW-1:0] r_shift;
  logic [DW-1:0]  r_coef [NTAPS];
  logic           r_pushout;
  logic [1:0]     r_cmd;
  logic [DW-1:0]  r_q;
  logic [DW-1:0]  r_h;
  logic           r_load_err;

  logic           w_accept;
  logic           w_cidx_ok;
  logic           w_cwrite;
  logic [AW-1:0]  w_koff;
  logic [DW-1:0]  w_tap_q;
  logic [DW-1:0]  w_h0;

  assign ready     = (r_state == IDLE) || (r_state == SEND);
  assign w_accept  = pushin && ready;
  assign w_cidx_ok = int'(cidx) < NTAPS;
  assign w_cwrite  = (r_state == IDLE) && cload && w_cidx_ok;

  // Tap offset of the command about to be registered: 1 when leaving FIRST,
  // k+1 while stepping through MAC.
  assign w_koff = (r_state == FIRST) ? AW'(1) : r_k + AW'(1);

  // A coefficient written on the accept edge is visible to the frame's
  // first command (write before first read).
  assign w_h0 = (w_cwrite && cidx == '0) ? cdata : r_coef[0];

  assign pushout   = r_pushout;
  assign cmd       = r_cmd;
  assign q         = r_q;
  assign h         = r_h;
  assign load_err  = r_load_err;
  assign dbg_state = r_state;

  sfilt_dline #(
    .NTAPS(NTAPS),
    .AW   (AW)
  ) u_dline (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_accept),
    .i_wr_data(x),
    .i_koff   (w_koff),
    .o_rd_data(w_tap_q)
  );

  // Outputs are registered for the state being entered, so each state's
  // command is visible during the cycle that state occupies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_shift    <= '0;
      r_pushout  <= 1'b0;
      r_cmd      <= CMD_FIRST;
      r_q        <= '0;
      r_h        <= '0;
      r_load_err <= 1'b0;
      for (int i = 0; i < NTAPS; i++) r_coef[i] <= '0;
    end else begin
      r_load_err <= cload && !w_cwrite;
      if (w_cwrite) r_coef[cidx] <= cdata;

      case (r_state)
        IDLE, SEND: begin
          if (w_accept) begin
            r_state   <= FIRST;
            r_shift   <= shift_amt;
            r_pushout <= 1'b1;
            r_cmd     <= CMD_FIRST;
            r_q       <= x;
            r_h       <= w_h0;
          end else begin
            r_state   <= IDLE;
            r_pushout <= 1'b0;
            r_cmd     <= CMD_FIRST;
            r_q       <= '0;
            r_h       <= '0;
          end
        end

        FIRST: begin
          if (NTAPS > 1) begin
            r_state   <= MAC;
            r_k       <= AW'(1);
            r_pushout <= 1'b1;
            r_cmd     <= CMD_MAC;
            r_q       <= w_tap_q;
            r_h       <= r_coef[w_koff];
          end else begin
            r_state   <= SHIFT;
            r_pushout <= 1'b1;
            r_cmd     <= CMD_SHIFT;
            r_q       <= '0;
            r_h       <= {{(DW-SHW){1'b0}}, r_shift};
          end
        end

        MAC: begin
          if (int'(r_k) == NTAPS - 1) begin
            r_state   <= SHIFT;
            r_pushout <= 1'b1;
            r_cmd     <= CMD_SHIFT;
            r_q       <= '0;
            r_h       <= {{(DW-SHW){1'b0}}, r_shift};
          end else begin
            r_state   <= MAC;
            r_k       <= w_koff;
            r_pushout <= 1'b1;
            r_cmd     <= CMD_MAC;
            r_q       <= w_tap_q;
            r_h       <= r_coef[w_koff];
          end
        end

        SHIFT: begin
          r_state   <= SEND;
          r_pushout <= 1'b1;
          r_cmd     <= CMD_SEND;
          r_q       <= '0;
          r_h       <= '0;
        end

        default: begin
          r_state   <= IDLE;
          r_pushout <= 1'b0;
          r_cmd     <= CMD_FIRST;
          r_q       <= '0;
          r_h       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfilt_seq.sv
// Bench for sfilt_seq: NTAPS=4 instance exercised with directed and random
// frames against a sample-history / coefficient model, plus an NTAPS=1
// instance for the degenerate frame.
module tb_sfilt_seq;
  import sfilt_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- NTAPS=4 instance ----------------
  logic        cload, load_err, pushin, ready, pushout;
  logic [1:0]  cidx, cmd;
  logic [31:0] cdata, x, q, h;
  logic [6:0]  shift_amt;
  seq_state_t  st;

  sfilt_seq #(.NTAPS(N)) dut (
    .clk(clk), .rst(rst), .cload(cload), .cidx(cidx), .cdata(cdata),
    .load_err(load_err), .shift_amt(shift_amt), .pushin(pushin), .x(x),
    .ready(ready), .pushout(pushout), .cmd(cmd), .q(q), .h(h),
    .dbg_state(st)
  );

  // ---------------- NTAPS=1 instance ----------------
  logic        cload_1, load_err_1, pushin_1, ready_1, pushout_1;
  logic [0:0]  cidx_1;
  logic [1:0]  cmd_1;
  logic [31:0] cdata_1, x_1, q_1, h_1;
  logic [6:0]  shift_amt_1;
  seq_state_t  st_1;

  sfilt_seq #(.NTAPS(1)) dut1 (
    .clk(clk), .rst(rst), .cload(cload_1), .cidx(cidx_1), .cdata(cdata_1),
    .load_err(load_err_1), .shift_amt(shift_amt_1), .pushin(pushin_1),
    .x(x_1), .ready(ready_1), .pushout(pushout_1), .cmd(cmd_1), .q(q_1),
    .h(h_1), .dbg_state(st_1)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int coef_m[N];
  int hist_q[$];   // accepted samples, most recent first

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [66:0] obs,
                     input logic [66:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, " out"}, {pushout, cmd, q, h}, 67'd0);
    chk({tag, " ready"}, 67'(ready), 67'd1);
  endtask

  // Called #1 after the accept edge; checks the whole frame and returns in
  // the SEND cycle. cl_at >= 0 injects a cload during that frame step.
  task automatic check_frame(input int xv, input int sh, input int cl_at);
    logic [66:0] e;
    int hk;
    hist_q.push_front(xv);
    if (hist_q.size() > N) void'(hist_q.pop_back());
    for (int i = 0; i < N + 2; i++) begin
      if (i == 0) e = {1'b1, CMD_FIRST, 32'(xv), 32'(coef_m[0])};
      else if (i < N) begin
        hk = (i < hist_q.size()) ? hist_q[i] : 0;
        e  = {1'b1, CMD_MAC, 32'(hk), 32'(coef_m[i])};
      end
      else if (i == N) e = {1'b1, CMD_SHIFT, 32'd0, 32'(sh)};
      else e = {1'b1, CMD_SEND, 64'd0};
      chk($sformatf("frame x=%0d step%0d", xv, i), {pushout, cmd, q, h}, e);
      chk($sformatf("frame x=%0d step%0d ready", xv, i), 67'(ready),
          67'(i == N + 1));
      chk($sformatf("frame x=%0d step%0d load_err", xv, i), 67'(load_err),
          67'(cl_at >= 0 && i == cl_at + 1));
      if (i == cl_at) begin
        cload = 1'b1; cidx = 2'd2; cdata = 32'd9;
      end
      if (i < N + 1) begin
        step;
        cload = 1'b0;
      end
    end
  endtask

  initial begin
    int xv, sh, ci, in_send;
    logic [31:0] cv;
    cload = 0; cidx = 0; cdata = 0; shift_amt = 0; pushin = 0; x = 0;
    cload_1 = 0; cidx_1 = 0; cdata_1 = 0; shift_amt_1 = 0; pushin_1 = 0;
    x_1 = 0;
    for (int i = 0; i < N; i++) coef_m[i] = 0;

    // Reset state
    rst = 1'b1;
    step; step;
    idle_check("reset");
    chk("reset load_err", 67'(load_err), 67'd0);
    rst = 1'b0;

    // Coefficients 1..4
    for (int i = 0; i < N; i++) begin
      cload = 1'b1; cidx = 2'(i); cdata = 32'(i + 1);
      step;
      coef_m[i] = i + 1;
    end
    cload = 1'b0;
    chk("coef load_err", 67'(load_err), 67'd0);

    // First frame: x=10, shift=3
    pushin = 1; x = 10; shift_amt = 3; step; pushin = 0;
    check_frame(10, 3, -1);
    step; idle_check("after first");

    // Wrap-around: samples 1..5, one frame apart
    for (int s = 1; s <= 5; s++) begin
      pushin = 1; x = 32'(s); shift_amt = 7'(s); step; pushin = 0;
      check_frame(s, s, -1);
      step; idle_check($sformatf("wrap %0d", s));
    end

    // Back-to-back: 7 then 8 with pushin held
    pushin = 1; x = 7; shift_amt = 1; step;
    x = 8;
    check_frame(7, 1, -1);
    step; pushin = 0;
    check_frame(8, 1, -1);
    step; idle_check("b2b");

    // cload during MAC k=2 is dropped
    pushin = 1; x = 20; shift_amt = 2; step; pushin = 0;
    check_frame(20, 2, 2);
    step; idle_check("mac cload");

    // cload with pushin in IDLE: frame sees the new coefficient
    cload = 1; cidx = 2; cdata = 9; pushin = 1; x = 1; shift_amt = 0;
    step; cload = 0; pushin = 0;
    coef_m[2] = 9;
    check_frame(1, 0, -1);
    step; idle_check("idle cload");

    // Random frames, random coefficient updates, random back-to-back
    in_send = 0;
    repeat (25) begin
      xv = int'($urandom);
      sh = $urandom_range(0, 127);
      if (in_send == 0 && $urandom_range(0, 1) == 1) begin
        ci = $urandom_range(0, N - 1);
        cv = $urandom;
        cload = 1; cidx = 2'(ci); cdata = cv;
        coef_m[ci] = int'(cv);
      end
      pushin = 1; x = 32'(xv); shift_amt = 7'(sh); step;
      pushin = 0; cload = 0;
      check_frame(xv, sh, -1);
      in_send = $urandom_range(0, 1);
      if (in_send == 0) begin
        step; idle_check("random");
      end
    end
    if (in_send != 0) begin
      step; idle_check("random end");
    end

    // Reset during MAC k=2
    pushin = 1; x = 30; shift_amt = 5; step; pushin = 0;
    step; step;
    rst = 1; step; rst = 0;
    idle_check("mid reset");
    chk("mid reset load_err", 67'(load_err), 67'd0);
    for (int i = 0; i < N; i++) coef_m[i] = 0;
    hist_q.delete();
    pushin = 1; x = 6; shift_amt = 0; step; pushin = 0;
    check_frame(6, 0, -1);
    step; idle_check("post reset");

    // NTAPS=1 instance
    cload_1 = 1; cidx_1 = 0; cdata_1 = 5; step;
    cidx_1 = 1; cdata_1 = 77; step;
    cload_1 = 0;
    chk("n1 bad idx load_err", 67'(load_err_1), 67'd1);
    pushin_1 = 1; x_1 = -32'sd3; shift_amt_1 = 0; step; pushin_1 = 0;
    chk("n1 load_err clear", 67'(load_err_1), 67'd0);
    chk("n1 first", {pushout_1, cmd_1, q_1, h_1},
        {1'b1, CMD_FIRST, 32'hFFFF_FFFD, 32'd5});
    chk("n1 first ready", 67'(ready_1), 67'd0);
    step;
    chk("n1 shift", {pushout_1, cmd_1, q_1, h_1},
        {1'b1, CMD_SHIFT, 32'd0, 32'd0});
    step;
    chk("n1 send", {pushout_1, cmd_1, q_1, h_1},
        {1'b1, CMD_SEND, 32'd0, 32'd0});
    chk("n1 send ready", 67'(ready_1), 67'd1);
    step;
    chk("n1 idle", {pushout_1, cmd_1, q_1, h_1}, 67'd0);
    chk("n1 idle ready", 67'(ready_1), 67'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sfilt_seq.md
Name: sfilt_seq

Overview:
- Command sequencer and initiator for the serial filter. It drives the filter's pushin/cmd/q/h interface.
- Holds NTAPS coefficients and a circular delay line of the last NTAPS input samples.
- For each accepted sample it emits one full FIR frame to the filter, one command per cycle: first-mult, (NTAPS-1) mult-accumulates, shift/round, send-and-clear.
- Sits between the sample source and sfilt.

Parameters:
- NTAPS, 8, number of filter taps; legal range 1..64.
- AW, $clog2(NTAPS) (minimum 1), index width for coefficients and delay line.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cload  in  1  coefficient write strobe.
- cidx  in  AW  coefficient index for the write.
- cdata  in  32  signed coefficient value.
- load_err  out  1  one-cycle pulse when a cload is dropped.
- shift_amt  in  7  right-shift amount used in the frame's cmd 2.
- pushin  in  1  sample valid.
- x  in  32  signed input sample.
- ready  out  1  sample accepted when pushin && ready.
- pushout  out  1  command valid toward the filter.
- cmd  out  2  0=first mult, 1=mult-acc, 2=shift/round, 3=send/clear.
- q  out  32  sample operand.
- h  out  32  coefficient operand; carries the shift amount in h[6:0] when cmd=2.

Behaviour:
- Reset (synchronous, on clk edge with rst=1):
  - state=IDLE; pushout=0, cmd=0, q=0, h=0, load_err=0.
  - ready=1 once state is IDLE (ready is combinational from state).
  - All coefficients and delay-line entries cleared to 0; write pointer wp=0.
  - Reset mid-frame abandons the frame. No further pushout until a new sample is accepted.
- States and transitions:
  - IDLE -> FIRST on accept.
  - FIRST -> MAC if NTAPS>1, else -> SHIFT.
  - MAC runs NTAPS-1 cycles with tap counter k=1..NTAPS-1, then -> SHIFT.
  - SHIFT -> SEND.
  - SEND -> FIRST if a sample is accepted in that cycle, else -> IDLE.
- ready=1 in IDLE and SEND only. Back-to-back frames therefore give continuous pushout: one sample per NTAPS+2 cycles.
- On accept:
  - x is written to dline[wp]; latest=wp; wp advances modulo NTAPS.
  - shift_amt is latched for that frame.
  - Outputs are registered: the first command appears on the cycle after the accept edge.
- Emitted commands (pushout=1 in every non-IDLE state):
  - FIRST: cmd=0, q=dline[latest], h=coef[0].
  - MAC step k: cmd=1, q=dline[(latest-k) mod NTAPS], h=coef[k]. Wrap-around is explicit modulo NTAPS; NTAPS need not be a power of 2.
  - SHIFT: cmd=2, q=0, h={25'b0, latched shift}. Emitted even when shift=0.
  - SEND: cmd=3, q=0, h=0.
  - In IDLE: pushout=0, q=0, h=0, cmd=0.
- Delay-line history: after reset, unfilled history entries read as 0, so early frames see zero history.
- Coefficient loads:
  - cload is honoured only in IDLE; coef[cidx] is written at the edge.
  - cload in IDLE with cidx >= NTAPS: dropped, load_err pulses.
  - cload in any other state: dropped, load_err pulses on the next cycle.
  - cload and pushin accepted in the same IDLE cycle: the frame uses the new coefficient (write before first read).
- Filter interface: the filter has no backpressure, so the sequencer never stalls mid-frame.

Decomposition:
- Package sfilt_pkg:
  - cmd code constants CMD_FIRST=2'd0, CMD_MAC=2'd1, CMD_SHIFT=2'd2, CMD_SEND=2'd3.
  - seq_state_t enum {IDLE, FIRST, MAC, SHIFT, SEND}.
  - Width constants DW=32, SHW=7.
- Sub-module sfilt_dline:
  - NTAPS x 32 circular sample buffer.
  - Owns wp/latest and a modulo-NTAPS read port addressed by tap offset k.
  - Synchronous clear on rst.
- Top module holds the FSM, tap counter, coefficient array and output registers.

Test Plan (NTAPS=4, coef={1,2,3,4} unless noted):
- First frame after reset: x=10, shift=3 -> pushout for 6 cycles: (0,10,1), (1,0,2), (1,0,3), (1,0,4), (2,0,3), (3,0,0); then pushout=0 and ready=1.
- Wrap-around: samples 1..5 fed one frame apart -> 5th frame q sequence 5,4,3,2 with h 1,2,3,4.
- Back-to-back: pushin held high with x=7,8 -> second frame's cmd0 (q=8) follows the first frame's cmd3 with no gap; pushout stays 1 for 12 cycles; ready low except IDLE/SEND.
- Load rules:
  - cload cidx=2 cdata=9 during MAC -> load_err pulses once, coef[2] stays 3.
  - Same cload in IDLE together with pushin x=1 -> frame shows h=9 at k=2.
- Reset mid-frame: rst asserted during MAC k=2 -> next cycle pushout=0, q=h=cmd=0, ready=1. Next sample x=6 -> (0,6,0), (1,0,0)... since coefficients were cleared.
- NTAPS=1 build: x=-3, coef[0]=5, shift=0 -> (0,-3,5), (2,0,0), (3,0,0).
